bus_decoder: RTL and testbench



---
 rtl/bus_decoder_pkg.sv | 21 ++
 rtl/bus_watchdog.sv | 33 +++
 rtl/bus_decoder.sv | 125 ++++++++++++
 tb/tb_bus_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_decoder_pkg.sv
// Shared definitions for the bus decoder: bus widths, the reference memory map
// and the base/mask address match used by both hardware and software.
package bus_decoder_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WR_W   = 4;
  localparam int CNT_W  = 16;

  // Reference two-slave memory map; software headers are generated from these values.
  localparam int                        MAP_NSLAVES = 2;
  localparam logic [32*MAP_NSLAVES-1:0] MAP_BASE    = {32'h1000_0000, 32'h0000_0000};
  localparam logic [32*MAP_NSLAVES-1:0] MAP_MASK    = {32'hF000_0000, 32'hF000_0000};

  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating 16-bit access-cycle counter; flags expiry on the last cycle a slave
// is allowed before the decoder must answer with a timeout error.
module bus_watchdog
  import bus_decoder_pkg::*;
#(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A timeout of zero disables the watchdog entirely.
  localparam bit               WD_ON = (timeout_cycles != 0);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(timeout_cycles - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = WD_ON && (count_reg == LIMIT);

endmodule

// File: rtl/bus_decoder.sv
// Single-master to N-slave address decoder with a bus watchdog: routes each
// request to the lowest matching slave, and errors on unmapped or stalled accesses.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter int                      nslaves        = 4,
  parameter logic [32*nslaves-1:0]   slave_base     = {nslaves{32'h0}},
  parameter logic [32*nslaves-1:0]   slave_mask     = {nslaves{32'h0}},
  parameter int unsigned             timeout_cycles = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        master_address,
  input  logic [DATA_W-1:0]        master_data_i,
  input  logic [WR_W-1:0]          master_wr,
  input  logic                     master_enable,
  output logic [DATA_W-1:0]        master_data_o,
  output logic                     master_ready,
  output logic                     master_error,
  output logic [ADDR_W-1:0]        slave_address,
  output logic [DATA_W-1:0]        slave_data_o,
  output logic [WR_W-1:0]          slave_wr,
  output logic [nslaves-1:0]       slave_enable,
  input  logic [32*nslaves-1:0]    slave_data_i,
  input  logic [nslaves-1:0]       slave_ready,
  input  logic [nslaves-1:0]       slave_error
);

  localparam int SEL_W = (nslaves > 1) ? $clog2(nslaves) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    ERR_RESP = 2'd2
  } state_t;

  state_t             state_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic [SEL_W-1:0]   hit_idx;
  logic [nslaves-1:0] hit;
  logic               any_hit;
  logic               sel_ready;
  logic               sel_error;
  logic               expired;

  assign slave_address = master_address;
  assign slave_data_o  = master_data_i;
  assign slave_wr      = master_wr;

  generate
    for (genvar gi = 0; gi < nslaves; gi++) begin : g_match
      assign hit[gi] = addr_hit(master_address, slave_base[32*gi +: 32], slave_mask[32*gi +: 32]);
    end
  endgenerate

  // Overlapping windows resolve to the lowest slave index.
  always_comb begin
    hit_idx = '0;
    for (int i = nslaves - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = SEL_W'(i);
    end
  end

  assign any_hit   = |hit;
  assign sel_ready = slave_ready[sel_reg];
  assign sel_error = slave_error[sel_reg];

  bus_watchdog #(
    .timeout_cycles(timeout_cycles)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_reg != ACCESS),
    .enable (state_reg == ACCESS),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (master_enable) begin
            if (any_hit) begin
              sel_reg   <= hit_idx;
              state_reg <= ACCESS;
            end else begin
              state_reg <= ERR_RESP;
            end
          end
        end
        ACCESS: begin
          // A slave response on the expiry cycle takes priority over the timeout.
          if (sel_ready || sel_error || !master_enable) begin
            state_reg <= IDLE;
          end else if (expired) begin
            state_reg <= ERR_RESP;
          end
        end
        ERR_RESP: state_reg <= IDLE;
        default:  state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    slave_enable  = '0;
    master_ready  = 1'b0;
    master_error  = 1'b0;
    master_data_o = '0;
    case (state_reg)
      ACCESS: begin
        slave_enable[sel_reg] = master_enable;
        master_ready          = sel_ready;
        master_error          = sel_error;
        master_data_o         = slave_data_i[sel_reg*32 +: 32];
      end
      ERR_RESP: master_error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Bench for bus_decoder: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_bus_decoder;

  localparam int NS = 4;
  localparam int TO = 4;
  localparam logic [32*NS-1:0] BASE = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [32*NS-1:0] MASK = {32'hF000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hF000_0000};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      master_address = '0;
  logic [31:0]      master_data_i = '0;
  logic [3:0]       master_wr = '0;
  logic             master_enable = 1'b0;
  logic [31:0]      master_data_o;
  logic             master_ready;
  logic             master_error;
  logic [31:0]      slave_address;
  logic [31:0]      slave_data_o;
  logic [3:0]       slave_wr;
  logic [NS-1:0]    slave_enable;
  logic [32*NS-1:0] slave_data_i = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
  logic [NS-1:0]    slave_ready = '0;
  logic [NS-1:0]    slave_error = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_decoder #(
    .nslaves       (NS),
    .slave_base    (BASE),
    .slave_mask    (MASK),
    .timeout_cycles(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .master_address(master_address),
    .master_data_i (master_data_i),
    .master_wr     (master_wr),
    .master_enable (master_enable),
    .master_data_o (master_data_o),
    .master_ready  (master_ready),
    .master_error  (master_error),
    .slave_address (slave_address),
    .slave_data_o  (slave_data_o),
    .slave_wr      (slave_wr),
    .slave_enable  (slave_enable),
    .slave_data_i  (slave_data_i),
    .slave_ready   (slave_ready),
    .slave_error   (slave_error)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: which slave (if any) owns the bus, how many access
  // cycles it has used, and whether an error response is owed this cycle.
  int m_tgt = -1;
  int m_age = 0;
  bit m_err = 1'b0;

  function automatic int target_of(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if (((a ^ BASE[32*i +: 32]) & MASK[32*i +: 32]) == 32'h0) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tgt = -1;
      m_age = 0;
      m_err = 1'b0;
    end else if (m_err) begin
      m_err = 1'b0;
    end else if (m_tgt >= 0) begin
      m_age++;
      if (slave_ready[m_tgt] || slave_error[m_tgt]) begin
        $display("txn slave=%0d cycles=%0d end=%s", m_tgt, m_age, slave_ready[m_tgt] ? "ready" : "slave-error");
        m_tgt = -1;
      end else if (!master_enable) begin
        $display("txn slave=%0d cycles=%0d end=abort", m_tgt, m_age);
        m_tgt = -1;
      end else if (m_age == TO) begin
        $display("txn slave=%0d cycles=%0d end=timeout", m_tgt, m_age);
        m_tgt = -1;
        m_err = 1'b1;
      end
    end else if (master_enable) begin
      m_tgt = target_of(master_address);
      m_age = 0;
      if (m_tgt < 0) begin
        $display("txn addr=%h end=unmapped", master_address);
        m_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [NS-1:0] e_en;
    logic          e_rdy;
    logic          e_err;
    logic [31:0]   e_dat;
    e_en  = '0;
    e_rdy = 1'b0;
    e_err = 1'b0;
    e_dat = '0;
    if (m_err) begin
      e_err = 1'b1;
    end else if (m_tgt >= 0) begin
      e_en[m_tgt] = master_enable;
      e_rdy       = slave_ready[m_tgt];
      e_err       = slave_error[m_tgt];
      e_dat       = slave_data_i[32*m_tgt +: 32];
    end
    chk("cyc_slave_enable", 32'(slave_enable), 32'(e_en));
    chk("cyc_ready", 32'(master_ready), 32'(e_rdy));
    chk("cyc_error", 32'(master_error), 32'(e_err));
    chk("cyc_data", master_data_o, e_dat);
    chk("cyc_addr", slave_address, master_address);
    chk("cyc_wdata", slave_data_o, master_data_i);
    chk("cyc_wr", 32'(slave_wr), 32'(master_wr));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    master_enable = 1'b0;
    slave_ready   = '0;
    slave_error   = '0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: r[31:28] = 4'h0;
      1: r[31:28] = 4'h1;
      2: r[31:24] = 8'h20;
      3: r[31:28] = 4'h2;
      default: r[31:28] = 4'($urandom_range(3, 15));
    endcase
    return r;
  endfunction

  initial begin
    bit quiet;
    quiet = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_slave_enable", 32'(slave_enable), 32'h0);
    chk("reset_ready", 32'(master_ready), 32'h0);
    chk("reset_error", 32'(master_error), 32'h0);
    chk("reset_data", master_data_o, 32'h0);
    rst = 1'b0;

    // Mapped read, slave1 answers on its first enabled cycle.
    step(); master_address = 32'h1000_0004; master_enable = 1'b1;
    #1 chk("t1_c0_enable", 32'(slave_enable), 32'h0);
    step(); slave_ready = 4'b0010; slave_data_i[63:32] = 32'hDEAD_BEEF;
    #1 chk("t1_enable", 32'(slave_enable), 32'h2);
    chk("t1_ready", 32'(master_ready), 32'h1);
    chk("t1_data", master_data_o, 32'hDEAD_BEEF);
    step(); idle_inputs();
    #1 chk("t1_after_ready", 32'(master_ready), 32'h0);

    // Unmapped access.
    step(); master_address = 32'h8000_0000; master_enable = 1'b1;
    #1 chk("t2_c0_error", 32'(master_error), 32'h0);
    step();
    #1 chk("t2_error", 32'(master_error), 32'h1);
    chk("t2_enable", 32'(slave_enable), 32'h0);
    step(); master_enable = 1'b0;
    #1 chk("t2_error_one_cycle", 32'(master_error), 32'h0);

    // Timeout: slave0 never answers.
    step(); master_address = 32'h0000_0010; master_enable = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      step();
      #1 chk($sformatf("t3_enable_c%0d", k), 32'(slave_enable), 32'h1);
      chk($sformatf("t3_error_c%0d", k), 32'(master_error), 32'h0);
    end
    step();
    #1 chk("t3_timeout_error", 32'(master_error), 32'h1);
    chk("t3_timeout_enable", 32'(slave_enable), 32'h0);
    step(); master_enable = 1'b0;
    #1 chk("t3_after_error", 32'(master_error), 32'h0);

    // Ready on the last allowed access cycle wins over the timeout.
    step(); master_address = 32'h0000_0020; master_enable = 1'b1;
    for (int k = 1; k < TO; k++) begin
      step();
      #1 chk($sformatf("t4_enable_c%0d", k), 32'(slave_enable), 32'h1);
    end
    step(); slave_ready = 4'b0001;
    #1 chk("t4_ready", 32'(master_ready), 32'h1);
    chk("t4_no_error", 32'(master_error), 32'h0);
    step(); idle_inputs();
    #1 chk("t4_after_error", 32'(master_error), 32'h0);

    // Abort in the second access cycle, then a fresh request to slave0.
    step(); master_address = 32'h1000_0008; master_enable = 1'b1;
    step();
    #1 chk("t5_enable", 32'(slave_enable), 32'h2);
    step(); master_enable = 1'b0;
    #1 chk("t5_abort_enable", 32'(slave_enable), 32'h0);
    chk("t5_abort_ready", 32'(master_ready), 32'h0);
    chk("t5_abort_error", 32'(master_error), 32'h0);
    step(); master_address = 32'h0000_0100; master_enable = 1'b1;
    step(); slave_ready = 4'b0001;
    #1 chk("t5_new_enable", 32'(slave_enable), 32'h1);
    chk("t5_new_ready", 32'(master_ready), 32'h1);
    step(); idle_inputs();

    // Reset in the middle of an access to slave2, then access slave3.
    step(); master_address = 32'h2000_0040; master_enable = 1'b1;
    step();
    #1 chk("t6_enable", 32'(slave_enable), 32'h4);
    slave_ready = 4'b0100;
    rst = 1'b1;
    #1 chk("t6_rst_enable", 32'(slave_enable), 32'h0);
    chk("t6_rst_ready", 32'(master_ready), 32'h0);
    chk("t6_rst_error", 32'(master_error), 32'h0);
    chk("t6_rst_data", master_data_o, 32'h0);
    step(); rst = 1'b0; idle_inputs();
    step(); master_address = 32'h2100_0000; master_enable = 1'b1;
    step(); slave_ready = 4'b1000; slave_data_i[127:96] = 32'h1234_5678;
    #1 chk("t6_new_enable", 32'(slave_enable), 32'h8);
    chk("t6_new_ready", 32'(master_ready), 32'h1);
    chk("t6_new_data", master_data_o, 32'h1234_5678);
    step(); idle_inputs();

    // Randomized traffic; long silent stretches force timeouts.
    for (int c = 0; c < 3000; c++) begin
      step();
      if ((c % 200) == 0) quiet = ($urandom_range(0, 2) == 0);
      for (int s = 0; s < NS; s++) begin
        slave_data_i[32*s +: 32] = $urandom;
        slave_ready[s] = !quiet && ($urandom_range(0, 3) == 0);
        slave_error[s] = !quiet && ($urandom_range(0, 11) == 0);
      end
      master_data_i = $urandom;
      master_wr     = 4'($urandom);
      if (m_tgt >= 0) begin
        master_enable = ($urandom_range(0, 19) != 0);
      end else if (!m_err) begin
        master_enable = ($urandom_range(0, 2) != 0);
        if (master_enable) master_address = pick_addr();
      end
    end

    step(); idle_inputs();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
